muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit in the MIPS execute stage, directly upstream of the HI/LO register pair. Accepts one MULT/MULTU/DIV/DIVU operation through a valid/ready handshake and computes it over multiple cycles while the pipeline stalls on `busy`. On completion it emits a single-cycle joint write pulse with the 64-bit result, which the HI/LO registers capture on the same edge.

## Interface
No parameters; data width is fixed at 32.
- `clk` input 1 — single clock; all state updates on rising edge.
- `resetn` input 1 — asynchronous, active-low reset.
- `in_valid` input 1 — operation request.
- `in_ready` output 1 — high exactly when state is IDLE.
- `op` input 2 — 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- `a`, `b` input 32 — rs, rt operands (dividend a, divisor b).
- `flush` input 1 — pipeline flush or exception; aborts the in-flight op.
- `busy` output 1 — state != IDLE; the pipeline stalls on it.
- `hi_write`, `lo_write` output 1 — result write pulse; always asserted together.
- `hi_data`, `lo_data` output 32 — result, valid while the write pulse is high.

## Operation
- Accept occurs when `in_valid && in_ready && !flush` at a rising edge. Operands and op are latched; `in_valid` is ignored whenever not IDLE.
- States: IDLE → RUN → DONE → IDLE.
  - RUN holds a 6-bit counter and performs one iteration per cycle for 32 cycles.
  - DONE lasts exactly one cycle; the write pulse is high for that cycle.
- Signed ops: compute on magnitudes (|x| of 0x80000000 is 2^31, held in 33 bits or unsigned 32), then apply sign fixup.
- Multiply: shift-add over 32 iterations into a 64-bit accumulator. hi = product[63:32], lo = product[31:0]. Signed product is negated if the operand signs differ.
- Divide: restoring division, one quotient bit per iteration. lo = quotient, hi = remainder.
  - Signed quotient is negative iff the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - Arithmetic is mod 2^32: DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- Divide by zero, DIV or DIVU: lo = 0xFFFFFFFF, hi = a unmodified, with no sign fixup. Latency is unchanged.
- Flush:
  - In RUN: go to IDLE next edge, no write pulse.
  - In DONE: the write pulse is gated off combinationally and the state returns to IDLE.
  - In IDLE: blocks accept.
- Reset (asynchronous, any state, including mid-operation): state IDLE, counter 0, `hi_data` = `lo_data` = 0, `hi_write` = `lo_write` = 0, `busy` 0, `in_ready` 1. No partial result is ever written.

## Timing
- Accept edge = edge 0. RUN occupies cycles 1..32 (edges 1..32 perform iterations 0..31).
- DONE is cycle 33: `hi_write`/`lo_write` are high and HI/LO capture at the end of cycle 33.
- `in_ready` is high again in cycle 34. A back-to-back accept is possible on the edge ending cycle 34.
- Divide latency is 33 cycles accept-to-write. Multiply latency is 33 cycles, or 1 with the fast multiply option.
- `hi_data`/`lo_data` are registered outputs; they hold their last value outside DONE and are don't-care there.
- `busy` is high from cycle 1 through cycle 33 inclusive.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU compute the 64-bit product in a single cycle (accept → DONE directly, write in cycle 1, `in_ready` in cycle 2).
  - Divide is unchanged.
- Undefined: multiply uses the 32-iteration shift-add path with 33-cycle latency. The only area cost is the shared accumulator.

## Test plan
- DIVU a=100, b=7 → single pulse in cycle 33 with lo=14, hi=2; `busy` high cycles 1..33; `in_ready` high in cycle 34.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MULT 0xFFFFFFFF×2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU same operands → hi=1, lo=0xFFFFFFFE. Latency is 1 with `MULDIV_FAST_MUL_EN`, else 33.
- DIVU 5/0 and DIV 0xFFFFFFFB/0 → lo=0xFFFFFFFF, hi=a exactly; no hang, latency 33.
- Start DIVU, assert `flush` in cycle 10 → no write pulse ever; IDLE/`in_ready` in cycle 11. Flush in DONE cycle → pulse suppressed. A new `in_valid` while busy → ignored, no second result.
- Deassert `resetn` in cycle 15 of a DIV → outputs immediately 0/IDLE. After release, a fresh DIVU 9/3 → lo=3, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit feeding the HI/LO register pair.
// Optional single-cycle multiply when MULDIV_FAST_MUL_EN is defined.
module muldiv_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc, acc_nxt, final_res;
  logic [W-1:0]   opnd, a_orig;
  logic           is_div, neg_q, neg_r, div_zero;

  logic           in_signed, accept, fast_op;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum, shifted;
  logic           ge;
  logic [W-1:0]   rem, q_fix, r_fix;
  logic [2*W-1:0] prod_fix;

  // Operand magnitudes; |0x80000000| is 2^31 as an unsigned 32-bit value
  always_comb begin
    in_signed = ~op[0];
    a_mag     = (in_signed && a[W-1]) ? W'(-a) : a;
    b_mag     = (in_signed && b[W-1]) ? W'(-b) : b;
    accept    = in_valid && (state == S_IDLE) && !flush;
`ifdef MULDIV_FAST_MUL_EN
    fast_op   = ~op[1];
`else
    fast_op   = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state and handshake/write outputs; flush gates the DONE pulse
  always_comb begin
    state_nxt = state;
    in_ready  = (state == S_IDLE);
    busy      = (state != S_IDLE);
    hi_write  = (state == S_DONE) && !flush;
    lo_write  = (state == S_DONE) && !flush;
    case (state)
      S_IDLE: if (accept) state_nxt = fast_op ? S_DONE : S_RUN;
      S_RUN: begin
        if (flush)                  state_nxt = S_IDLE;
        else if (cnt == LAST_ITER)  state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One shift-add or restoring-divide step over the shared accumulator
  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
    shifted = {acc[2*W-1:W], acc[W-1]};
    ge      = (shifted >= {1'b0, opnd});
    rem     = ge ? (shifted[W-1:0] - opnd) : shifted[W-1:0];
    acc_nxt = is_div ? {rem, acc[W-2:0], ge} : {mul_sum, acc[W-1:1]};
  end

  // Sign fixup on the last iteration's result; divide-by-zero bypasses it
  always_comb begin
    prod_fix = neg_q ? (2*W)'(-acc_nxt) : acc_nxt;
    q_fix    = neg_q ? W'(-acc_nxt[W-1:0]) : acc_nxt[W-1:0];
    r_fix    = neg_r ? W'(-acc_nxt[2*W-1:W]) : acc_nxt[2*W-1:W];
    if (!is_div)      final_res = prod_fix;
    else if (div_zero) final_res = {a_orig, {W{1'b1}}};
    else              final_res = {r_fix, q_fix};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_prod, fast_res;
  always_comb begin
    fast_prod = (2*W)'(a_mag) * (2*W)'(b_mag);
    fast_res  = (in_signed && (a[W-1] ^ b[W-1])) ? (2*W)'(-fast_prod) : fast_prod;
  end
`endif

  // Datapath registers and registered result
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_orig   <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi_data  <= '0;
      lo_data  <= '0;
    end else if (accept) begin
      cnt      <= '0;
      is_div   <= op[1];
      neg_q    <= in_signed && (a[W-1] ^ b[W-1]);
      neg_r    <= in_signed && a[W-1];
      div_zero <= op[1] && (b == '0);
      a_orig   <= a;
      opnd     <= op[1] ? b_mag : a_mag;
      acc      <= op[1] ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
`ifdef MULDIV_FAST_MUL_EN
      if (fast_op) {hi_data, lo_data} <= fast_res;
`endif
    end else if (state == S_RUN) begin
      cnt <= cnt + CW'(1);
      acc <= acc_nxt;
      if (cnt == LAST_ITER && !flush) {hi_data, lo_data} <= final_res;
    end
  end

endmodule
